// File: rtl/latch_wr_arbiter.sv
// Round-robin write arbiter that sequences a transparent latch through SETUP/OPEN/HOLD.
// Define LATCH_READBACK_EN to add the latch_q input and the rb_err readback-compare output.
module latch_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 1,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       latch_data,
  output logic                   latch_en,
  output logic [IW-1:0]          grant_id,
`ifdef LATCH_READBACK_EN
  input  logic [WIDTH-1:0]       latch_q,
  output logic                   rb_err,
`endif
  output logic [1:0]             state_dbg
);

  // Handshake: a requester raises req (level) and holds it until its ack bit
  // pulses for one cycle; req_data is sampled only on the grant edge.

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt;
  logic          found;

  // First set request searching upward from rr_ptr with wrap.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      grant_id   <= '0;
      latch_data <= '0;
      latch_en   <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (found) begin
            latch_data <= req_data[int'(gnt)*WIDTH +: WIDTH];
            grant_id   <= gnt;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          latch_en <= 1'b1;
          cnt      <= 4'(EN_CYCLES - 1);
          state    <= OPEN;
        end
        OPEN: begin
          if (cnt == 4'd0) begin
            latch_en <= 1'b0;
            ack      <= N_REQ'(1) << grant_id;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          ack    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

`ifdef LATCH_READBACK_EN
  // ack is only high in HOLD, so this pulse is coincident with it.
  assign rb_err = (|ack) && (latch_q != latch_data);
`endif

endmodule
